// File: rtl/word_counter.sv
// Per-FIFO popped-word counters for output FIFOs 4-7 with an IDLE-gated readout port.
// Optional build macro WORD_COUNTER_SAT_EN: counters saturate instead of wrapping.
module word_counter #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pop4,
   input  logic             pop5,
   input  logic             pop6,
   input  logic             pop7,
   input  logic             empty4,
   input  logic             empty5,
   input  logic             empty6,
   input  logic             empty7,
   input  logic             IDLE,
   input  logic             req,
   input  logic [1:0]       idx,
   output logic             valid_contador,
   output logic [CNT_W-1:0] contador_out
);

   typedef enum logic {
      RD_IDLE,
      RD_RESP
   } rd_state_t;

   rd_state_t        state, next_state;
   logic [CNT_W-1:0] cnt [4];
   logic [3:0]       pop_v, empty_v, inc;
   logic             capture;

   assign pop_v   = {pop7, pop6, pop5, pop4};
   assign empty_v = {empty7, empty6, empty5, empty4};
   assign inc     = pop_v & ~empty_v;
   assign capture = req && IDLE;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned k = 0; k < 4; k++) cnt[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (inc[k]) begin
`ifdef WORD_COUNTER_SAT_EN
               if (cnt[k] != '1) cnt[k] <= cnt[k] + CNT_W'(1);
`else
               cnt[k] <= cnt[k] + CNT_W'(1);
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= RD_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = RD_IDLE;
      if (capture) next_state = RD_RESP;
   end

   // Capture samples the counter before this edge's increment lands.
   always_ff @(posedge clk) begin
      if (reset)        contador_out <= '0;
      else if (capture) contador_out <= cnt[idx];
   end

   assign valid_contador = (state == RD_RESP);

endmodule

// File: tb/tb_word_counter.sv
// Directed self-checking bench for word_counter (default width 5).
module tb_word_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       pop4, pop5, pop6, pop7;
   logic       empty4, empty5, empty6, empty7;
   logic       IDLE, req;
   logic [1:0] idx;
   logic       valid_contador;
   logic [4:0] contador_out;

   int n_total = 0;
   int n_bad   = 0;

   word_counter #(.CNT_W(5)) dut (
      .clk(clk), .reset(reset),
      .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
      .empty4(empty4), .empty5(empty5), .empty6(empty6), .empty7(empty7),
      .IDLE(IDLE), .req(req), .idx(idx),
      .valid_contador(valid_contador), .contador_out(contador_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pops(input logic [3:0] p, input logic [3:0] e);
      {pop7, pop6, pop5, pop4}         = p;
      {empty7, empty6, empty5, empty4} = e;
   endtask

   task automatic do_pops(input logic [3:0] p, input logic [3:0] e, input int n);
      set_pops(p, e);
      for (int i = 0; i < n; i++) tick();
      set_pops(4'h0, 4'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [1:0] i, input logic [31:0] exp);
      req  = 1'b1;
      IDLE = 1'b1;
      idx  = i;
      tick();
      chk({tag, "_valid"}, 32'(valid_contador), 32'd1);
      chk(tag, 32'(contador_out), exp);
      req = 1'b0;
   endtask

   initial begin
      reset = 1'b1; IDLE = 1'b1; req = 1'b1; idx = 2'd0;
      set_pops(4'hF, 4'h0);
      tick();
      tick();
      chk("rst_valid", 32'(valid_contador), 32'd0);
      chk("rst_out",   32'(contador_out),   32'd0);
      reset = 1'b0; req = 1'b0;
      set_pops(4'h0, 4'h0);
      tick();
      rd("rst_cnt0", 2'd0, 0);
      rd("rst_cnt1", 2'd1, 0);
      rd("rst_cnt2", 2'd2, 0);
      rd("rst_cnt3", 2'd3, 0);
      tick();
      chk("rst_drop_valid", 32'(valid_contador), 32'd0);

      // basic counting: 4 valid pops on every FIFO, then back-to-back reads
      do_reset();
      do_pops(4'hF, 4'h0, 4);
      rd("basic_cnt0", 2'd0, 4);
      rd("basic_cnt1", 2'd1, 4);
      rd("basic_cnt2", 2'd2, 4);
      rd("basic_cnt3", 2'd3, 4);
      tick();
      chk("basic_drop_valid", 32'(valid_contador), 32'd0);
      chk("basic_hold_out",   32'(contador_out),   32'd4);

      // empty filtering on FIFO5
      do_reset();
      do_pops(4'b0010, 4'b0010, 3);
      do_pops(4'b0010, 4'b0000, 2);
      rd("empty_cnt1", 2'd1, 2);
      rd("empty_cnt0", 2'd0, 0);

      // same-edge read and increment on FIFO6
      do_reset();
      do_pops(4'b0100, 4'h0, 7);
      set_pops(4'b0100, 4'h0);
      rd("same_edge_pre", 2'd2, 7);
      set_pops(4'h0, 4'h0);
      rd("same_edge_post", 2'd2, 8);

      // gating: req with IDLE low, pops on FIFO4 keep counting
      req = 1'b1; IDLE = 1'b0; idx = 2'd0;
      set_pops(4'b0001, 4'h0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("gate_valid", 32'(valid_contador), 32'd0);
         chk("gate_out",   32'(contador_out),   32'd8);
         tick();
      end
      set_pops(4'h0, 4'h0);
      IDLE = 1'b1;
      tick();
      chk("gate_open_valid", 32'(valid_contador), 32'd1);
      chk("gate_open_out",   32'(contador_out),   32'd6);

      // reset aborts a read in progress
      reset = 1'b1;
      tick();
      reset = 1'b0; req = 1'b0;
      chk("abort_valid", 32'(valid_contador), 32'd0);
      chk("abort_out",   32'(contador_out),   32'd0);

      // overflow boundary on FIFO7
      do_pops(4'b1000, 4'h0, 31);
      rd("ovf_max", 2'd3, 31);
      do_pops(4'b1000, 4'h0, 2);
`ifdef WORD_COUNTER_SAT_EN
      rd("ovf_33", 2'd3, 31);
`else
      rd("ovf_33", 2'd3, 1);
`endif
      tick();
      chk("end_valid", 32'(valid_contador), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
